junction_controller: RTL and testbench
======================================

// Module: junction_controller
// PURPOSE
//   Sequences two traffic_lights instances (road A, road B) at one junction.
//   Drives each light's toggle input, confirms transitions from its LED outputs,
//   and enforces an all-red gap between the roads. Vehicle requests extend or
//   end each green phase. Sits directly above the two traffic_lights instances.
// PARAMETERS
//   MIN_GREEN        32'd20  minimum green, in ce-qualified cycles
//   MAX_GREEN        32'd100 green length that forces a change with no demand (>= MIN_GREEN)
//   ALL_RED_TIME     32'd4   all-red gap between phases, in ce cycles
//   CONFIRM_TIMEOUT  32'd64  ce cycles to wait for LED confirmation (> AMBER_TIME+2)
// PORTS
//   clk       in   1  system clock
//   rst       in   1  synchronous, active-high reset
//   ce        in   1  clock enable; FSM, timers and request latches advance only when high
//   req_a     in   1  vehicle waiting on road A (level; latched internally)
//   req_b     in   1  vehicle waiting on road B
//   a_red     in   1  red_led of light A
//   a_green   in   1  green_led of light A
//   b_red     in   1  red_led of light B
//   b_green   in   1  green_led of light B
//   toggle_a  out  1  one-cycle pulse to light A toggle
//   toggle_b  out  1  one-cycle pulse to light B toggle
//   grant_a   out  1  road A holds right-of-way (high in GREEN_A only)
//   grant_b   out  1  road B holds right-of-way (high in GREEN_B only)
//   fault     out  1  sticky fault flag
//   state_o   out  3  current FSM state encoding (debug)
// BEHAVIOUR
//   Light contract: a toggle pulse moves a light red->green, or green->amber->red.
//   Reset: state=ALL_RED, next_road=A, timer=0, latches=0; all outputs 0.
//   All outputs are registered. No output changes on a cycle where ce=0,
//     except fault. toggle_x is forced 0 when ce=0.
//   FSM states: ALL_RED, GO_A, GREEN_A, STOP_A, GO_B, GREEN_B, STOP_B, FAULT.
//   - ALL_RED: counts ALL_RED_TIME ce cycles, then enters GO_<next_road>.
//   - GO_x: toggle_x=1 on the first ce cycle in the state only. Then waits for x_green=1
//     and enters GREEN_x. Timeout is CONFIRM_TIMEOUT ce cycles; on timeout -> FAULT.
//   - GREEN_x: grant_x=1; timer is cleared on entry.
//     Exits to STOP_x when timer >= MIN_GREEN and (latch_other or timer >= MAX_GREEN).
//   - STOP_x: grant_x=0; toggle_x=1 on the first ce cycle only. Waits for x_red=1, or
//     FAULT on timeout. Then enters ALL_RED with next_road=other.
//   - FAULT: sticky until rst. toggles=0, grants=0, fault=1.
//   Request latches: req_x=1 with ce=1 sets latch_x. Entering GREEN_x clears latch_x.
//     Clear wins over a simultaneous set.
//   Safety: a_green & b_green in any cycle (ce ignored) -> FAULT on the next edge.
//     Any x_green=1 while in ALL_RED -> FAULT.
//   Timer: 32-bit, saturating, cleared on every state change.
//   Reset mid-operation: returns to ALL_RED immediately. Lights must be re-initialised
//     red alongside rst, otherwise the ALL_RED safety check raises FAULT.
//   Latency: toggle_x rises 1 clk after entering GO_x/STOP_x with ce=1.
// STRUCTURE
//   Package junction_pkg: state localparams (3-bit), ROAD_A=1'b0 / ROAD_B=1'b1,
//     width constant TIMER_W=32.
//   One sub-module: phase_timer. It provides a clear/enable 32-bit saturating
//     counter with >= compare outputs for MIN_GREEN, MAX_GREEN, ALL_RED_TIME and
//     CONFIRM_TIMEOUT.
// TESTING (benches use two traffic_lights instances with AMBER_TIME=10; ce=1 unless stated)
//   1 Reset, no requests -> toggle_a pulses after 4 cycles; grant_a holds 100 cycles;
//     then STOP_A, then B gets green. Cycle repeats.
//   2 req_b pulsed at green cycle 5 -> A leaves green at cycle 20 (MIN_GREEN).
//     B green follows after amber(10) + confirm + 4 all-red.
//   3 req_a held during GO_A->GREEN_A entry -> latch_a reads 0 after entry (clear wins).
//   4 ce low for 30 cycles mid GREEN_A -> timer frozen, grant_a held, no toggles.
//     Phase extends by 30 cycles.
//   5 Force b_green=1 while a_green=1 -> fault=1 next edge, grants/toggles 0.
//     Fault stays set until rst.
//   6 Light A stuck (a_red never rises in STOP_A) -> fault=1 after 64 ce cycles.
//     rst mid-GREEN_B returns to ALL_RED with outputs 0.

Source files
------------

// File: rtl/junction_pkg.sv
// Shared types and constants for the junction controller and its phase timer.
package junction_pkg;

  localparam int unsigned TIMER_W = 32;

  localparam logic ROAD_A = 1'b0;
  localparam logic ROAD_B = 1'b1;

  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    GO_A    = 3'd1,
    GREEN_A = 3'd2,
    STOP_A  = 3'd3,
    GO_B    = 3'd4,
    GREEN_B = 3'd5,
    STOP_B  = 3'd6,
    FAULT   = 3'd7
  } state_t;

  // True once the ce cycle in progress completes 'limit' cycles in the state,
  // so a phase lasts exactly 'limit' ce cycles from a cleared count.
  function automatic logic elapsed(input logic [TIMER_W-1:0] count,
                                   input logic [TIMER_W-1:0] limit);
    return ({1'b0, count} + {{TIMER_W{1'b0}}, 1'b1}) >= {1'b0, limit};
  endfunction

endpackage

// File: rtl/junction_controller_phase_timer.sv
// Clear/enable saturating phase counter with the four phase-length compares.
module phase_timer
  import junction_pkg::*;
#(
  parameter logic [TIMER_W-1:0] MIN_GREEN       = 32'd20,
  parameter logic [TIMER_W-1:0] MAX_GREEN       = 32'd100,
  parameter logic [TIMER_W-1:0] ALL_RED_TIME    = 32'd4,
  parameter logic [TIMER_W-1:0] CONFIRM_TIMEOUT = 32'd64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [TIMER_W-1:0] count,
  output logic               min_green_done,
  output logic               max_green_done,
  output logic               all_red_done,
  output logic               confirm_expired
);

  // Count enabled cycles, holding at all-ones; clear has priority.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign min_green_done  = elapsed(count, MIN_GREEN);
  assign max_green_done  = elapsed(count, MAX_GREEN);
  assign all_red_done    = elapsed(count, ALL_RED_TIME);
  assign confirm_expired = elapsed(count, CONFIRM_TIMEOUT);

endmodule

// File: rtl/junction_controller.sv
// Two-road junction sequencer driving and confirming a pair of traffic lights.
module junction_controller
  import junction_pkg::*;
#(
  parameter logic [TIMER_W-1:0] MIN_GREEN       = 32'd20,
  parameter logic [TIMER_W-1:0] MAX_GREEN       = 32'd100,
  parameter logic [TIMER_W-1:0] ALL_RED_TIME    = 32'd4,
  parameter logic [TIMER_W-1:0] CONFIRM_TIMEOUT = 32'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       a_red,
  input  logic       a_green,
  input  logic       b_red,
  input  logic       b_green,
  output logic       toggle_a,
  output logic       toggle_b,
  output logic       grant_a,
  output logic       grant_b,
  output logic       fault,
  output logic [2:0] state_o
);

  state_t             state, state_nx;
  logic               next_road;
  logic               latch_a, latch_b;
  logic               unsafe, state_chg, first_ce;
  logic [TIMER_W-1:0] timer;
  logic               min_green_done, max_green_done, all_red_done, confirm_expired;

  phase_timer #(
    .MIN_GREEN       (MIN_GREEN),
    .MAX_GREEN       (MAX_GREEN),
    .ALL_RED_TIME    (ALL_RED_TIME),
    .CONFIRM_TIMEOUT (CONFIRM_TIMEOUT)
  ) u_timer (
    .clk             (clk),
    .rst             (rst),
    .clr             (state_chg),
    .en              (ce),
    .count           (timer),
    .min_green_done  (min_green_done),
    .max_green_done  (max_green_done),
    .all_red_done    (all_red_done),
    .confirm_expired (confirm_expired)
  );

  // Safety violations are checked every cycle, independent of ce.
  assign unsafe    = (a_green & b_green) | ((state == ALL_RED) & (a_green | b_green));
  assign state_chg = (state_nx != state);
  // Timer is zero only until the first ce cycle in a state has been counted.
  assign first_ce  = ce && (timer == '0) && !state_chg;
  assign state_o   = state;

  // Next-state decision; normal progress only on ce, safety faults at any time.
  always_comb begin
    state_nx = state;
    if (state != FAULT) begin
      if (unsafe) begin
        state_nx = FAULT;
      end else if (ce) begin
        unique case (state)
          ALL_RED: if (all_red_done) state_nx = (next_road == ROAD_A) ? GO_A : GO_B;
          GO_A:    if (a_green) state_nx = GREEN_A;
                   else if (confirm_expired) state_nx = FAULT;
          GREEN_A: if (min_green_done && (latch_b || max_green_done)) state_nx = STOP_A;
          STOP_A:  if (a_red) state_nx = ALL_RED;
                   else if (confirm_expired) state_nx = FAULT;
          GO_B:    if (b_green) state_nx = GREEN_B;
                   else if (confirm_expired) state_nx = FAULT;
          GREEN_B: if (min_green_done && (latch_a || max_green_done)) state_nx = STOP_B;
          STOP_B:  if (b_red) state_nx = ALL_RED;
                   else if (confirm_expired) state_nx = FAULT;
          default: state_nx = FAULT;
        endcase
      end
    end
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ALL_RED;
      next_road <= ROAD_A;
      latch_a   <= 1'b0;
      latch_b   <= 1'b0;
      toggle_a  <= 1'b0;
      toggle_b  <= 1'b0;
      grant_a   <= 1'b0;
      grant_b   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state    <= state_nx;
      toggle_a <= first_ce && ((state == GO_A) || (state == STOP_A));
      toggle_b <= first_ce && ((state == GO_B) || (state == STOP_B));
      grant_a  <= (state_nx == GREEN_A);
      grant_b  <= (state_nx == GREEN_B);
      if (state_nx == FAULT) fault <= 1'b1;
      if ((state == STOP_A) && (state_nx == ALL_RED)) next_road <= ROAD_B;
      if ((state == STOP_B) && (state_nx == ALL_RED)) next_road <= ROAD_A;
      // Entry into a green clears that road's latch even if its request is still high.
      if (ce) begin
        latch_a <= ((state_nx == GREEN_A) && (state != GREEN_A)) ? 1'b0 : (latch_a | req_a);
        latch_b <= ((state_nx == GREEN_B) && (state != GREEN_B)) ? 1'b0 : (latch_b | req_b);
      end
    end
  end

endmodule

// File: tb/tb_junction_controller.sv
// Directed bench for junction_controller with two behavioural traffic lights.
module tb_junction_controller;

  localparam int AMBER_TIME = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic       a_red, a_green, b_red, b_green;
  logic       toggle_a, toggle_b, grant_a, grant_b, fault;
  logic [2:0] state_o;

  logic force_bg = 1'b0;
  logic stuck_a  = 1'b0;
  int   la_st, lb_st, la_cnt, lb_cnt;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  junction_controller #(
    .MIN_GREEN       (32'd20),
    .MAX_GREEN       (32'd100),
    .ALL_RED_TIME    (32'd4),
    .CONFIRM_TIMEOUT (32'd64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .req_a    (req_a),
    .req_b    (req_b),
    .a_red    (a_red),
    .a_green  (a_green),
    .b_red    (b_red),
    .b_green  (b_green),
    .toggle_a (toggle_a),
    .toggle_b (toggle_b),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .fault    (fault),
    .state_o  (state_o)
  );

  // Light models: 0=red, 1=green, 2=amber; toggle moves red->green or green->amber->red.
  always @(posedge clk) begin
    if (rst) begin
      la_st <= 0; la_cnt <= 0;
    end else begin
      case (la_st)
        0: if (toggle_a) la_st <= 1;
        1: if (toggle_a) begin la_st <= 2; la_cnt <= 0; end
        default: if (!stuck_a) begin
          if (la_cnt == AMBER_TIME - 1) la_st <= 0;
          else la_cnt <= la_cnt + 1;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      lb_st <= 0; lb_cnt <= 0;
    end else begin
      case (lb_st)
        0: if (toggle_b) lb_st <= 1;
        1: if (toggle_b) begin lb_st <= 2; lb_cnt <= 0; end
        default: begin
          if (lb_cnt == AMBER_TIME - 1) lb_st <= 0;
          else lb_cnt <= lb_cnt + 1;
        end
      endcase
    end
  end

  assign a_red   = (la_st == 0);
  assign a_green = (la_st == 1);
  assign b_red   = (lb_st == 0);
  assign b_green = (lb_st == 1) | force_bg;

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves rst low at a falling edge; the next rising edge is the first active one.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic sig(input int idx);
    case (idx)
      0:       return toggle_a;
      1:       return toggle_b;
      2:       return grant_a;
      3:       return grant_b;
      4:       return fault;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_level(input int idx, input logic lvl, input int max_cycles,
                            output int n, output bit ok);
    n  = 0;
    ok = 1'b1;
    while (sig(idx) !== lvl) begin
      if (n >= max_cycles) begin
        ok = 1'b0;
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state_o !== 3'd0) begin
      fails++; $display("FAIL reset_state: got %0d want 0", state_o);
    end
    checks++;
    if ({toggle_a, toggle_b, grant_a, grant_b} !== 4'b0000) begin
      fails++; $display("FAIL reset_outputs: got %b want 0000", {toggle_a, toggle_b, grant_a, grant_b});
    end
    checks++;
    if (fault !== 1'b0) begin
      fails++; $display("FAIL reset_fault: got %b want 0", fault);
    end
  endtask

  task automatic test_no_request();
    int n; bit ok;
    do_reset();
    wait_level(0, 1'b1, 50, n, ok);
    checks++;
    if (!ok || n !== 5) begin
      fails++; $display("FAIL go_a_latency: got %0d cycles (ok=%0d) want 5", n, ok);
    end
    tick();
    checks++;
    if (toggle_a !== 1'b0) begin
      fails++; $display("FAIL toggle_a_pulse_width: got %b want 0", toggle_a);
    end
    wait_level(2, 1'b1, 20, n, ok);
    checks++;
    if (!ok || n !== 1 || state_o !== 3'd2) begin
      fails++; $display("FAIL green_a_entry: got %0d cycles state %0d want 1 cycle state 2", n, state_o);
    end
    wait_level(2, 1'b0, 200, n, ok);
    checks++;
    if (!ok || n !== 100) begin
      fails++; $display("FAIL max_green_a: got %0d cycles want 100", n);
    end
    wait_level(3, 1'b1, 100, n, ok);
    checks++;
    if (!ok || n !== 20) begin
      fails++; $display("FAIL a_to_b_gap: got %0d cycles want 20", n);
    end
    wait_level(3, 1'b0, 200, n, ok);
    checks++;
    if (!ok || n !== 100) begin
      fails++; $display("FAIL max_green_b: got %0d cycles want 100", n);
    end
    wait_level(2, 1'b1, 100, n, ok);
    checks++;
    if (!ok || n !== 20) begin
      fails++; $display("FAIL b_to_a_gap: got %0d cycles want 20", n);
    end
  endtask

  task automatic test_request_b();
    int n; bit ok;
    do_reset();
    wait_level(2, 1'b1, 50, n, ok);
    repeat (5) tick();
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    wait_level(2, 1'b0, 200, n, ok);
    checks++;
    if (!ok || (n + 6) !== 20) begin
      fails++; $display("FAIL min_green_on_req: got %0d cycles want 20", n + 6);
    end
    wait_level(3, 1'b1, 100, n, ok);
    checks++;
    if (!ok || n !== 20) begin
      fails++; $display("FAIL req_b_gap: got %0d cycles want 20", n);
    end
    wait_level(3, 1'b0, 200, n, ok);
    checks++;
    if (!ok || n !== 100) begin
      fails++; $display("FAIL green_b_after_req: got %0d cycles want 100", n);
    end
  endtask

  task automatic test_req_held_entry();
    int n; bit ok;
    do_reset();
    req_a = 1'b1;
    wait_level(2, 1'b1, 50, n, ok);
    checks++;
    if (!ok || dut.latch_a !== 1'b0) begin
      fails++; $display("FAIL latch_a_clear_wins: got %b want 0", dut.latch_a);
    end
    req_a = 1'b0;
    wait_level(2, 1'b0, 200, n, ok);
    wait_level(3, 1'b1, 100, n, ok);
    wait_level(3, 1'b0, 200, n, ok);
    checks++;
    if (!ok || n !== 100) begin
      fails++; $display("FAIL green_b_no_stale_a: got %0d cycles want 100", n);
    end
  endtask

  task automatic test_ce_freeze();
    int n; bit ok; bit bad;
    do_reset();
    wait_level(2, 1'b1, 50, n, ok);
    repeat (10) tick();
    ce  = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      tick();
      if (toggle_a !== 1'b0 || toggle_b !== 1'b0 || grant_a !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      fails++; $display("FAIL ce_hold_outputs: outputs changed with ce low, want grant_a=1 toggles=0");
    end
    checks++;
    if (dut.timer !== 32'd10) begin
      fails++; $display("FAIL ce_timer_frozen: got %0d want 10", dut.timer);
    end
    ce = 1'b1;
    wait_level(2, 1'b0, 200, n, ok);
    checks++;
    if (!ok || (n + 40) !== 130) begin
      fails++; $display("FAIL ce_phase_extend: got %0d cycles want 130", n + 40);
    end
  endtask

  task automatic test_dual_green();
    int n; bit ok;
    do_reset();
    wait_level(2, 1'b1, 50, n, ok);
    force_bg = 1'b1;
    tick();
    force_bg = 1'b0;
    checks++;
    if (fault !== 1'b1 || state_o !== 3'd7) begin
      fails++; $display("FAIL dual_green_fault: got fault=%b state=%0d want 1/7", fault, state_o);
    end
    checks++;
    if ({toggle_a, toggle_b, grant_a, grant_b} !== 4'b0000) begin
      fails++; $display("FAIL fault_outputs: got %b want 0000", {toggle_a, toggle_b, grant_a, grant_b});
    end
    repeat (20) tick();
    checks++;
    if (fault !== 1'b1 || state_o !== 3'd7) begin
      fails++; $display("FAIL fault_sticky: got fault=%b state=%0d want 1/7", fault, state_o);
    end
    do_reset();
    checks++;
    if (fault !== 1'b0 || state_o !== 3'd0) begin
      fails++; $display("FAIL fault_cleared_by_rst: got fault=%b state=%0d want 0/0", fault, state_o);
    end
  endtask

  task automatic test_stuck_light();
    int n; bit ok;
    do_reset();
    stuck_a = 1'b1;
    req_b   = 1'b1;
    wait_level(2, 1'b1, 50, n, ok);
    req_b = 1'b0;
    wait_level(2, 1'b0, 200, n, ok);
    wait_level(4, 1'b1, 200, n, ok);
    checks++;
    if (!ok || n !== 64 || state_o !== 3'd7) begin
      fails++; $display("FAIL stop_a_timeout: got %0d cycles state %0d want 64 state 7", n, state_o);
    end
    stuck_a = 1'b0;
    do_reset();
    req_b = 1'b1;
    wait_level(3, 1'b1, 200, n, ok);
    req_b = 1'b0;
    repeat (5) tick();
    checks++;
    if (!ok || state_o !== 3'd5) begin
      fails++; $display("FAIL reach_green_b: got state %0d want 5", state_o);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (state_o !== 3'd0 || {toggle_a, toggle_b, grant_a, grant_b, fault} !== 5'b00000) begin
      fails++; $display("FAIL rst_mid_green_b: got state %0d outs %b want 0 00000",
                        state_o, {toggle_a, toggle_b, grant_a, grant_b, fault});
    end
    rst = 1'b0;
    wait_level(0, 1'b1, 50, n, ok);
    checks++;
    if (!ok || n !== 5 || fault !== 1'b0) begin
      fails++; $display("FAIL restart_after_rst: got %0d cycles fault=%b want 5 fault=0", n, fault);
    end
  endtask

  initial begin
    test_reset();
    test_no_request();
    test_request_b();
    test_req_held_entry();
    test_ce_freeze();
    test_dual_green();
    test_stuck_light();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
